mode_transition_controller: RTL and testbench
=============================================

Name: mode_transition_controller

Overview:
- Central mode register of the exhaust-hood controller.
- Consumes debounced single-cycle button pulses and the auto-return request from the third-mode countdown controller. Produces `current_mode`, which that controller and the fan/display blocks read.
- Enforces the transition rules between the modes:
  - third mode is entered only by button;
  - third mode is left only by the auto-return request;
  - third mode cannot be re-entered until a cooldown window has elapsed.

Parameters:
- `COOLDOWN_CYCLES`, default 100_000_000: clocks after leaving THIRD before THIRD may be requested again (1 s at 100 MHz).
- `CNT_WIDTH`, default 27: cooldown counter width. Must hold `COOLDOWN_CYCLES`.

Ports:
- `clk`  input  1  100 MHz system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `btn_stand`  input  1  debounced single-cycle pulse, request STAND.
- `btn_first`  input  1  debounced single-cycle pulse, request FIRST.
- `btn_second`  input  1  debounced single-cycle pulse, request SECOND.
- `btn_third`  input  1  debounced single-cycle pulse, request THIRD.
- `third_return_req`  input  1  level from the third-mode countdown controller. High means the THIRD time is up. That controller holds it high while `current_mode` is THIRD and clears it once the mode leaves THIRD.
- `current_mode`  output  `MODE_WIDTH`  registered mode. Encodings are `STAND_MODE` / `FIRST_MODE` / `SECOND_MODE` / `THIRD_MODE` from `parameters.vh`.
- `mode_changed`  output  1  one-cycle pulse in the cycle after `current_mode` takes a new value.
- `third_locked`  output  1  high while the cooldown is running.
- `third_rejected`  output  1  one-cycle pulse when `btn_third` is refused.

Behaviour:
- One clock. Asynchronous, active-high reset. All outputs are registered.
- Reset values:
  - `current_mode` = `STAND_MODE`;
  - `mode_changed` = 0, `third_locked` = 0, `third_rejected` = 0;
  - cooldown counter = 0.
- Reset asserted mid-THIRD or mid-cooldown returns to STAND immediately, with the lock cleared.
- Latency: a request seen at edge N updates `current_mode` at edge N+1. `mode_changed` is high during cycle N+2.
- Button priority when several pulses coincide: stand > third > second > first.
- Transitions out of STAND, FIRST and SECOND:
  - `btn_third` goes to THIRD if `third_locked` = 0. If locked, it raises `third_rejected`, and the next-lower-priority button pulsed in the same cycle is honoured instead.
  - `btn_second` goes to SECOND; `btn_first` goes to FIRST.
  - `btn_stand` goes to STAND.
  - A request for the mode already active produces no change and no `mode_changed`.
- Transitions out of THIRD:
  - all buttons are ignored, and `third_rejected` never fires;
  - `third_return_req` = 1 goes to STAND and starts the cooldown.
- `third_return_req` is ignored in every other mode. This covers the one stale cycle after leaving THIRD.
- Cooldown:
  - On the THIRD→STAND edge, the counter loads `COOLDOWN_CYCLES` and `third_locked` goes to 1.
  - The counter decrements every clock.
  - When it reaches 0, `third_locked` goes to 0 in that same register update.
  - The counter keeps running regardless of mode changes among STAND, FIRST and SECOND.
  - `COOLDOWN_CYCLES` = 0 means `third_locked` never asserts.
- The counter saturates at 0 and never wraps.
- Mode encoding: any `current_mode` value outside the four defined encodings (not reachable in normal operation) recovers to STAND on the next clock, with a `mode_changed` pulse.

Test Plan:
- Reset, then `btn_first` at cycle 5 → `current_mode` = FIRST at cycle 6. `mode_changed` is high exactly during cycle 7.
- From FIRST, pulse `btn_stand`, `btn_third` and `btn_second` in the same cycle → STAND. No `third_rejected`.
- From SECOND, `btn_third` → THIRD. Then `btn_first` and `btn_stand` pulses → mode stays THIRD. Raise `third_return_req` → STAND one cycle later, and `third_locked` = 1.
- With `COOLDOWN_CYCLES` = 8 and the exit from THIRD at edge N:
  - `btn_third` at N+4 → `third_rejected` pulse, mode stays STAND;
  - `third_locked` falls at edge N+8;
  - `btn_third` at N+9 → THIRD.
- During cooldown, pulse `btn_third` and `btn_first` in the same cycle → FIRST, plus a `third_rejected` pulse.
- Assert `rst` while in THIRD with `third_return_req` = 0 → immediate STAND with `third_locked` = 0. `btn_third` right after release → THIRD.

Source files
------------

// File: rtl/mode_transition_controller.sv
// Central mode register of the exhaust-hood controller.
// Arbitrates button requests, holds THIRD until the countdown controller asks
// to return, and enforces a cooldown before THIRD may be entered again.
module mode_transition_controller #(
   parameter int unsigned COOLDOWN_CYCLES = 100_000_000,
   parameter int unsigned CNT_WIDTH       = 27,
   localparam int unsigned MODE_WIDTH     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_stand,
   input  logic                  btn_first,
   input  logic                  btn_second,
   input  logic                  btn_third,
   input  logic                  third_return_req,
   output logic [MODE_WIDTH-1:0] current_mode,
   output logic                  mode_changed,
   output logic                  third_locked,
   output logic                  third_rejected
);

   localparam logic [MODE_WIDTH-1:0] STAND_MODE  = MODE_WIDTH'(0);
   localparam logic [MODE_WIDTH-1:0] FIRST_MODE  = MODE_WIDTH'(1);
   localparam logic [MODE_WIDTH-1:0] SECOND_MODE = MODE_WIDTH'(2);
   localparam logic [MODE_WIDTH-1:0] THIRD_MODE  = MODE_WIDTH'(3);

   localparam logic [CNT_WIDTH-1:0] COOLDOWN_LOAD = CNT_WIDTH'(COOLDOWN_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

   logic [MODE_WIDTH-1:0] mode_next;
   logic                  reject_next;
   logic                  exit_third;
   logic [CNT_WIDTH-1:0]  cooldown_cnt;
   logic [CNT_WIDTH-1:0]  cnt_next;
   logic                  locked_next;
   // Set when the mode register changed on the previous edge; delays the pulse by one cycle.
   logic                  change_pending;

   // Next mode: THIRD exits only on return request; elsewhere buttons by priority.
   always_comb begin
      mode_next   = current_mode;
      reject_next = 1'b0;
      exit_third  = 1'b0;
      case (current_mode)
         THIRD_MODE: begin
            if (third_return_req) begin
               mode_next  = STAND_MODE;
               exit_third = 1'b1;
            end
         end
         STAND_MODE, FIRST_MODE, SECOND_MODE: begin
            if (btn_stand) begin
               mode_next = STAND_MODE;
            end else if (btn_third && !third_locked) begin
               mode_next = THIRD_MODE;
            end else begin
               // A locked-out THIRD request falls through to the lower buttons.
               reject_next = btn_third;
               if (btn_second) begin
                  mode_next = SECOND_MODE;
               end else if (btn_first) begin
                  mode_next = FIRST_MODE;
               end
            end
         end
         default: mode_next = STAND_MODE;
      endcase
   end

   // Cooldown: load on THIRD exit, then count down saturating at zero.
   always_comb begin
      cnt_next    = cooldown_cnt;
      locked_next = 1'b0;
      if (exit_third) begin
         cnt_next    = COOLDOWN_LOAD;
         locked_next = (COOLDOWN_LOAD != '0);
      end else if (cooldown_cnt != '0) begin
         cnt_next    = cooldown_cnt - CNT_ONE;
         // Lock drops in the same update that brings the counter to zero.
         locked_next = (cooldown_cnt != CNT_ONE);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         current_mode   <= STAND_MODE;
         change_pending <= 1'b0;
         mode_changed   <= 1'b0;
         third_locked   <= 1'b0;
         third_rejected <= 1'b0;
         cooldown_cnt   <= '0;
      end else begin
         current_mode   <= mode_next;
         change_pending <= (mode_next != current_mode);
         mode_changed   <= change_pending;
         third_locked   <= locked_next;
         third_rejected <= reject_next;
         cooldown_cnt   <= cnt_next;
      end
   end

endmodule

// File: tb/tb_mode_transition_controller.sv
// Directed self-checking bench for mode_transition_controller (cooldown = 8 cycles).
module tb_mode_transition_controller;

   localparam logic [1:0] STAND  = 2'd0;
   localparam logic [1:0] FIRST  = 2'd1;
   localparam logic [1:0] SECOND = 2'd2;
   localparam logic [1:0] THIRD  = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_stand = 1'b0;
   logic       btn_first = 1'b0;
   logic       btn_second = 1'b0;
   logic       btn_third = 1'b0;
   logic       third_return_req = 1'b0;
   logic [1:0] current_mode;
   logic       mode_changed;
   logic       third_locked;
   logic       third_rejected;

   int errors = 0;
   int checks = 0;

   mode_transition_controller #(
      .COOLDOWN_CYCLES(8),
      .CNT_WIDTH      (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .btn_stand       (btn_stand),
      .btn_first       (btn_first),
      .btn_second      (btn_second),
      .btn_third       (btn_third),
      .third_return_req(third_return_req),
      .current_mode    (current_mode),
      .mode_changed    (mode_changed),
      .third_locked    (third_locked),
      .third_rejected  (third_rejected)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset
      tick();
      tick();
      check("rst_mode", 32'(current_mode), 32'(STAND));
      check("rst_changed", 32'(mode_changed), 0);
      check("rst_locked", 32'(third_locked), 0);
      check("rst_rejected", 32'(third_rejected), 0);
      rst = 1'b0;
      tick();
      tick();
      tick();

      // FIRST with mode_changed one cycle after the mode update
      btn_first = 1'b1;
      tick();
      btn_first = 1'b0;
      check("first_mode", 32'(current_mode), 32'(FIRST));
      check("first_chg_early", 32'(mode_changed), 0);
      tick();
      check("first_chg_pulse", 32'(mode_changed), 1);
      tick();
      check("first_chg_end", 32'(mode_changed), 0);

      // stand beats third and second
      btn_stand = 1'b1; btn_third = 1'b1; btn_second = 1'b1;
      tick();
      btn_stand = 1'b0; btn_third = 1'b0; btn_second = 1'b0;
      check("prio_mode", 32'(current_mode), 32'(STAND));
      check("prio_noreject", 32'(third_rejected), 0);
      tick();
      tick();

      // Request for the active mode: no change, no pulse
      btn_stand = 1'b1;
      tick();
      btn_stand = 1'b0;
      tick();
      check("same_mode", 32'(current_mode), 32'(STAND));
      check("same_nochg", 32'(mode_changed), 0);

      // SECOND -> THIRD, buttons ignored in THIRD
      btn_second = 1'b1;
      tick();
      btn_second = 1'b0;
      check("second_mode", 32'(current_mode), 32'(SECOND));
      btn_third = 1'b1;
      tick();
      btn_third = 1'b0;
      check("third_mode", 32'(current_mode), 32'(THIRD));
      btn_first = 1'b1; btn_stand = 1'b1;
      tick();
      btn_first = 1'b0; btn_stand = 1'b0;
      check("third_hold", 32'(current_mode), 32'(THIRD));
      btn_third = 1'b1;
      tick();
      btn_third = 1'b0;
      check("third_hold2", 32'(current_mode), 32'(THIRD));
      check("third_noreject", 32'(third_rejected), 0);

      // Exit at edge N, cooldown of 8
      third_return_req = 1'b1;
      tick();                                    // N
      check("exit_mode", 32'(current_mode), 32'(STAND));
      check("exit_locked", 32'(third_locked), 1);
      tick();                                    // N+1, stale request ignored
      third_return_req = 1'b0;
      check("stale_req", 32'(current_mode), 32'(STAND));
      check("exit_chg", 32'(mode_changed), 1);
      tick();                                    // N+2
      tick();                                    // N+3
      btn_third = 1'b1;
      tick();                                    // N+4
      btn_third = 1'b0;
      check("cd_reject", 32'(third_rejected), 1);
      check("cd_mode", 32'(current_mode), 32'(STAND));
      tick();                                    // N+5
      check("cd_reject_end", 32'(third_rejected), 0);
      tick();                                    // N+6
      tick();                                    // N+7
      check("cd_locked_n7", 32'(third_locked), 1);
      tick();                                    // N+8
      check("cd_unlocked_n8", 32'(third_locked), 0);
      btn_third = 1'b1;
      tick();                                    // N+9
      btn_third = 1'b0;
      check("cd_reenter", 32'(current_mode), 32'(THIRD));

      // Locked third + first in same cycle -> FIRST with reject
      third_return_req = 1'b1;
      tick();
      third_return_req = 1'b0;
      check("exit2_locked", 32'(third_locked), 1);
      tick();
      tick();
      btn_third = 1'b1; btn_first = 1'b1;
      tick();
      btn_third = 1'b0; btn_first = 1'b0;
      check("fallthru_mode", 32'(current_mode), 32'(FIRST));
      check("fallthru_reject", 32'(third_rejected), 1);
      for (int i = 0; i < 10; i++) tick();
      check("cd2_done", 32'(third_locked), 0);

      // Reset mid-cooldown clears the lock immediately
      btn_third = 1'b1;
      tick();
      btn_third = 1'b0;
      check("third_again", 32'(current_mode), 32'(THIRD));
      third_return_req = 1'b1;
      tick();
      third_return_req = 1'b0;
      check("exit3_locked", 32'(third_locked), 1);
      #1 rst = 1'b1;
      #1;
      check("rst_cd_locked", 32'(third_locked), 0);
      check("rst_cd_mode", 32'(current_mode), 32'(STAND));
      rst = 1'b0;
      btn_third = 1'b1;
      tick();
      btn_third = 1'b0;
      check("post_rst_third", 32'(current_mode), 32'(THIRD));

      // Reset while in THIRD
      tick();
      #1 rst = 1'b1;
      #1;
      check("rst_third_mode", 32'(current_mode), 32'(STAND));
      check("rst_third_locked", 32'(third_locked), 0);
      rst = 1'b0;
      btn_third = 1'b1;
      tick();
      btn_third = 1'b0;
      check("post_rst2_third", 32'(current_mode), 32'(THIRD));
      check("post_rst2_noreject", 32'(third_rejected), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
